// File: rtl/deser_pkg.sv
// rtl/deser_pkg.sv - shared widths and types for the 16-bit deserializer
package deser_pkg;

  localparam int WORD_W = 16;
  localparam int IDX_W  = 4;

  typedef logic [WORD_W-1:0] word_t;
  typedef logic [IDX_W-1:0]  idx_t;

  // Index of the final bit of a word; reaching it completes the word.
  localparam idx_t LAST_IDX = idx_t'(WORD_W - 1);

endpackage

// File: rtl/decoder4_16.sv
// rtl/decoder4_16.sv - 4-to-16 one-hot write decoder with enable
module decoder4_16 (
  input  logic        en,
  input  logic [3:0]  sel,
  output logic [15:0] out
);

  // One-hot enable for the selected bit, all zero when disabled
  always_comb begin
    out = '0;
    if (en) begin
      out[sel] = 1'b1;
    end
  end

endmodule

// File: rtl/deser16_demux.sv
// rtl/deser16_demux.sv - serial-to-parallel word collector with valid/ready output
module deser16_demux
  import deser_pkg::*;
#(
  parameter bit MSB_FIRST = 1'b0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              clear,
  input  logic              in_valid,
  input  logic              in_bit,
  output logic              in_ready,
  output logic [WORD_W-1:0] out_word,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [IDX_W-1:0]  idx,
  output logic              busy
);

  idx_t  idx_q;
  word_t coll_q;
  word_t wr_en;
  word_t coll_next;
  idx_t  sel;
  logic  last;
  logic  acc;
  logic  out_take;

  assign last = (idx_q == LAST_IDX);

  // Only the final bit of a word can be blocked, and only while the
  // previous word is still waiting for its consumer.
  assign in_ready = ~(last & out_valid & ~out_ready);
  assign acc      = in_valid & in_ready & ~clear;
  assign out_take = out_valid & out_ready;

  // MSB-first mode fills bit 15 down to bit 0.
  assign sel = MSB_FIRST ? (LAST_IDX - idx_q) : idx_q;

  decoder4_16 u_dec (
    .en  (acc),
    .sel (sel),
    .out (wr_en)
  );

  // Enabled bit loads the incoming serial bit; every other bit holds.
  assign coll_next = (coll_q & ~wr_en) | ({WORD_W{in_bit}} & wr_en);

  assign idx  = idx_q;
  assign busy = (idx_q != '0);

  // Bit counter and collection register; clear aborts the partial word
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      idx_q  <= '0;
      coll_q <= '0;
    end else if (clear) begin
      idx_q  <= '0;
      coll_q <= '0;
    end else if (acc) begin
      if (last) begin
        idx_q  <= '0;
        coll_q <= '0;
      end else begin
        idx_q  <= idx_q + idx_t'(1);
        coll_q <= coll_next;
      end
    end
  end

  // Output holding register; a completing word overrides a same-cycle
  // handshake so back-to-back words leave no bubble.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      out_word  <= '0;
      out_valid <= 1'b0;
    end else if (acc && last) begin
      out_word  <= coll_next;
      out_valid <= 1'b1;
    end else if (out_take) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_deser16_demux.sv
// tb/tb_deser16_demux.sv - self-checking bench for deser16_demux
module tb_deser16_demux;

  logic        clk;
  logic        reset;
  logic        clear;
  logic        in_valid;
  logic        in_bit;
  logic        out_ready;
  logic        in_ready0, in_ready1;
  logic [15:0] out_word0, out_word1;
  logic        out_valid0, out_valid1;
  logic [3:0]  idx0, idx1;
  logic        busy0, busy1;

  int vectors;
  int miscompares;

  deser16_demux #(.MSB_FIRST(1'b0)) u_lsb (
    .clk(clk), .reset(reset), .clear(clear), .in_valid(in_valid), .in_bit(in_bit),
    .in_ready(in_ready0), .out_word(out_word0), .out_valid(out_valid0),
    .out_ready(out_ready), .idx(idx0), .busy(busy0)
  );

  deser16_demux #(.MSB_FIRST(1'b1)) u_msb (
    .clk(clk), .reset(reset), .clear(clear), .in_valid(in_valid), .in_bit(in_bit),
    .in_ready(in_ready1), .out_word(out_word1), .out_valid(out_valid1),
    .out_ready(out_ready), .idx(idx1), .busy(busy1)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    vectors++;
    assert (obs === exp)
    else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_bit(input logic b);
    in_valid = 1'b1;
    in_bit   = b;
    tick();
  endtask

  task automatic send_bits(input logic [15:0] w, input int n);
    for (int k = 0; k < n; k++) send_bit(w[k]);
    in_valid = 1'b0;
  endtask

  // Reference model state for the randomized run
  int          m_count;
  logic [15:0] m_cur_l, m_cur_m;
  logic [15:0] pend_l[$];
  logic [15:0] pend_m[$];
  int          words_made;
  int          words_taken;
  int          cycles;
  logic        exp_ready;

  initial begin
    vectors = 0; miscompares = 0;
    reset = 1'b1; clear = 1'b0; in_valid = 1'b0; in_bit = 1'b0; out_ready = 1'b0;
    #12;
    chk("reset_idx",       16'(idx0),       16'd0);
    chk("reset_out_valid", 16'(out_valid0), 16'd0);
    chk("reset_out_word",  out_word0,       16'h0000);
    chk("reset_in_ready",  16'(in_ready0),  16'd1);
    chk("reset_busy",      16'(busy0),      16'd0);
    #1 reset = 1'b0;

    // LSB-first word with the consumer always ready
    out_ready = 1'b1;
    send_bits(16'hA5C3, 8);
    chk("mid_busy", 16'(busy0), 16'd1);
    chk("mid_idx",  16'(idx0),  16'd8);
    send_bits(16'hA5C3 >> 8, 8);
    chk("a5c3_valid", 16'(out_valid0), 16'd1);
    chk("a5c3_word",  out_word0,       16'hA5C3);
    chk("a5c3_idx",   16'(idx0),       16'd0);
    tick();
    chk("a5c3_valid_drop", 16'(out_valid0), 16'd0);

    // Stream 1,0,0,...,0: bit 0 for LSB-first, bit 15 for MSB-first
    send_bits(16'h0001, 16);
    chk("msb_word", out_word1, 16'h8000);
    chk("lsb_word", out_word0, 16'h0001);
    tick();

    // Held word with stalled consumer while the next word streams in
    out_ready = 1'b0;
    send_bits(16'h1234, 16);
    chk("hold_valid", 16'(out_valid0), 16'd1);
    chk("hold_word",  out_word0,       16'h1234);
    send_bits(16'hBEEF, 15);
    in_valid = 1'b1; in_bit = 1'b1;
    #1;
    chk("stall_idx",      16'(idx0),      16'd15);
    chk("stall_in_ready", 16'(in_ready0), 16'd0);
    tick();
    chk("stall_idx_held", 16'(idx0),  16'd15);
    chk("stall_word",     out_word0,  16'h1234);
    out_ready = 1'b1;
    #1;
    chk("release_in_ready", 16'(in_ready0), 16'd1);
    tick();
    in_valid = 1'b0; out_ready = 1'b0;
    chk("b2b_valid", 16'(out_valid0), 16'd1);
    chk("b2b_word",  out_word0,       16'hBEEF);
    chk("b2b_idx",   16'(idx0),       16'd0);

    // Clear with a valid bit at idx 7; held word must be untouched
    send_bits(16'hFFFF, 7);
    chk("pre_clear_idx", 16'(idx0), 16'd7);
    clear = 1'b1; in_valid = 1'b1; in_bit = 1'b1;
    tick();
    clear = 1'b0; in_valid = 1'b0;
    chk("clear_idx",       16'(idx0),       16'd0);
    chk("clear_busy",      16'(busy0),      16'd0);
    chk("clear_out_valid", 16'(out_valid0), 16'd1);
    chk("clear_out_word",  out_word0,       16'hBEEF);
    out_ready = 1'b1;
    send_bits(16'h0F0F, 16);
    out_ready = 1'b0;
    chk("post_clear_valid", 16'(out_valid0), 16'd1);
    chk("post_clear_word",  out_word0,       16'h0F0F);

    // Asynchronous reset mid-cycle with a partial word and a held word
    send_bits(16'h0155, 9);
    chk("pre_rst_idx",   16'(idx0),       16'd9);
    chk("pre_rst_valid", 16'(out_valid0), 16'd1);
    #2 reset = 1'b1;
    #1;
    chk("arst_idx",      16'(idx0),       16'd0);
    chk("arst_valid",    16'(out_valid0), 16'd0);
    chk("arst_word",     out_word0,       16'h0000);
    chk("arst_in_ready", 16'(in_ready0),  16'd1);
    chk("arst_busy",     16'(busy0),      16'd0);
    #1 reset = 1'b0;

    // Randomized traffic against a word-level scoreboard
    m_count = 0; m_cur_l = '0; m_cur_m = '0;
    words_made = 0; words_taken = 0; cycles = 0;
    while (words_made < 1000 || pend_l.size() != 0) begin
      if (words_made < 1000) begin
        in_valid  = ($urandom_range(0, 3) != 0);
        in_bit    = 1'($urandom);
        out_ready = 1'($urandom);
      end else begin
        in_valid  = 1'b0;
        out_ready = 1'b1;
      end
      #1;
      exp_ready = !(m_count == 15 && pend_l.size() != 0 && !out_ready);
      chk("rnd_in_ready",  16'(in_ready0),  16'(exp_ready));
      chk("rnd_idx",       16'(idx0),       16'(m_count));
      chk("rnd_out_valid", 16'(out_valid0), 16'(pend_l.size() != 0));
      if (pend_l.size() != 0) begin
        chk("rnd_word_lsb", out_word0, pend_l[0]);
        chk("rnd_word_msb", out_word1, pend_m[0]);
      end
      if (pend_l.size() != 0 && out_ready) begin
        void'(pend_l.pop_front());
        void'(pend_m.pop_front());
        words_taken++;
      end
      if (in_valid && exp_ready) begin
        m_cur_l[m_count]      = in_bit;
        m_cur_m[15 - m_count] = in_bit;
        m_count++;
        if (m_count == 16) begin
          pend_l.push_back(m_cur_l);
          pend_m.push_back(m_cur_m);
          words_made++;
          m_count = 0; m_cur_l = '0; m_cur_m = '0;
        end
      end
      tick();
      cycles++;
      if (cycles > 80000) begin
        chk("rnd_cycle_budget", 16'(cycles), 16'd0);
        break;
      end
    end
    in_valid = 1'b0; out_ready = 1'b0;
    #1;
    chk("rnd_words_taken", 16'(words_taken), 16'd1000);
    chk("rnd_final_valid", 16'(out_valid0),  16'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
